// File: rtl/codec_i2c_sequencer.sv
// I2C write sequencer for codec register setup. Each 16-bit table entry is sent as one
// 3-byte write. Every byte's ACK is checked, and an entry that is NACKed is retried a bounded number of times.
module codec_i2c_sequencer #(
  parameter int                   N_REGS    = 9,
  parameter logic [16*N_REGS-1:0] REG_TABLE =
    144'h0217_0017_0812_0A00_1000_0E02_0C10_1E00_1201,
  parameter logic [6:0]           DEV_ADDR  = 7'h1A,
  parameter int                   CLK_DIV   = 125,
  parameter int                   MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] fail_idx,
  output logic [2:0] ack_status
);

  localparam int             TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [7:0]     LAST_IDX  = 8'(N_REGS - 1);
  localparam logic [3:0]     RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [7:0]     ADDR_BYTE = {DEV_ADDR, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    index_q, index_d;
  logic [3:0]    retry_q, retry_d;
  logic [2:0]    ack_cur_q, ack_cur_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [7:0]    fail_idx_q, fail_idx_d;
  logic [2:0]    ack_status_q, ack_status_d;

  logic          tick;
  logic [15:0]   word;

  assign tick = busy_q && (tick_cnt_q == TICK_LAST);

  // Constant part-selects keep the table lookup a plain mux on index_q.
  always_comb begin
    word = REG_TABLE[15:0];
    for (int i = 1; i < N_REGS; i++) begin
      if (index_q == 8'(i)) word = REG_TABLE[16*i +: 16];
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    qtr_d        = qtr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    index_d      = index_q;
    retry_d      = retry_q;
    ack_cur_d    = ack_cur_q;
    scl_d        = scl_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    fail_idx_d   = fail_idx_q;
    ack_status_d = ack_status_q;

    if (busy_q) tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d      = S_START;
          tick_cnt_d   = '0;
          qtr_d        = 2'd0;
          index_d      = 8'd0;
          retry_d      = 4'd0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          ack_status_d = 3'b000;
        end
      end
      default: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (state_q)
            S_START: begin
              case (qtr_q)
                2'd0: begin scl_d = 1'b1; sda_oe_d = 1'b0; end
                2'd1: sda_oe_d = 1'b1;
                2'd3: begin
                  scl_d      = 1'b0;
                  state_d    = S_BIT;
                  shift_d    = ADDR_BYTE;
                  bit_cnt_d  = 3'd7;
                  byte_cnt_d = 2'd0;
                  ack_cur_d  = 3'b000;
                end
                default: ;
              endcase
            end
            S_BIT: begin
              case (qtr_q)
                2'd0: sda_oe_d = ~shift_q[7];
                2'd1: scl_d = 1'b1;
                2'd3: begin
                  scl_d   = 1'b0;
                  shift_d = {shift_q[6:0], 1'b0};
                  if (bit_cnt_q == 3'd0) state_d = S_ACK;
                  else bit_cnt_d = bit_cnt_q - 3'd1;
                end
                default: ;
              endcase
            end
            S_ACK: begin
              case (qtr_q)
                2'd0: sda_oe_d = 1'b0;
                2'd1: scl_d = 1'b1;
                2'd2: ack_cur_d[byte_cnt_q] = ~sda;
                default: begin
                  scl_d = 1'b0;
                  // A NACK skips the remaining bytes; their ack bits stay 0.
                  if (ack_cur_q[byte_cnt_q] && byte_cnt_q != 2'd2) begin
                    state_d    = S_BIT;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    bit_cnt_d  = 3'd7;
                    shift_d    = (byte_cnt_q == 2'd0) ? word[15:8] : word[7:0];
                  end else begin
                    state_d = S_STOP;
                  end
                end
              endcase
            end
            S_STOP: begin
              case (qtr_q)
                2'd0: sda_oe_d = 1'b1;
                2'd1: scl_d = 1'b1;
                2'd2: sda_oe_d = 1'b0;
                default: state_d = S_GAP;
              endcase
            end
            S_GAP: begin
              if (qtr_q == 2'd3) begin
                ack_status_d = ack_cur_q;
                if (ack_cur_q == 3'b111) begin
                  if (index_q == LAST_IDX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                  end else begin
                    state_d = S_START;
                    index_d = index_q + 8'd1;
                    retry_d = 4'd0;
                  end
                end else if (retry_q < RETRY_MAX) begin
                  state_d = S_START;
                  retry_d = retry_q + 4'd1;
                end else begin
                  state_d    = S_FAIL;
                  error_d    = 1'b1;
                  fail_idx_d = index_q;
                  busy_d     = 1'b0;
                end
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      qtr_q        <= 2'd0;
      bit_cnt_q    <= 3'd7;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 8'd0;
      index_q      <= 8'd0;
      retry_q      <= 4'd0;
      ack_cur_q    <= 3'b000;
      scl_q        <= 1'b1;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      fail_idx_q   <= 8'd0;
      ack_status_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      qtr_q        <= qtr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      index_q      <= index_d;
      retry_q      <= retry_d;
      ack_cur_q    <= ack_cur_d;
      scl_q        <= scl_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      fail_idx_q   <= fail_idx_d;
      ack_status_q <= ack_status_d;
    end
  end

  // Open-drain data line: only ever pulls low or releases.
  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign scl        = scl_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign fail_idx   = fail_idx_q;
  assign ack_status = ack_status_q;

endmodule
